joker_ep_in_reply: RTL and testbench

//  EP1 IN reply buffer, directly downstream of the Joker command controller. Takes byte

---
 rtl/joker_ep_in_reply.sv | 194 +++++++++++++++++++
 tb/tb_joker_ep_in_reply.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joker_ep_in_reply.sv
// EP1 IN reply buffer: two-bank ping-pong RAM between the Joker command controller and the USB core.
// Optional stale-packet timeout enabled with `define JOKER_IN_TIMEOUT_EN.
module joker_ep_in_reply #(
    parameter int ADDR_W         = 11,
    parameter int ACK_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] usb_in_addr,
    input  logic [7:0]  usb_in_data,
    input  logic        usb_in_wren,
    input  logic        usb_in_commit,
    input  logic [10:0] usb_in_commit_len,
    output logic        usb_in_commit_ack,
    output logic        usb_in_ready,
    input  logic [10:0] ep_rd_addr,
    output logic [7:0]  ep_rd_data,
    output logic        ep_pkt_avail,
    output logic [10:0] ep_pkt_len,
    input  logic        ep_pkt_done,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {
        W_FILL = 2'd0,
        W_ACK  = 2'd1,
        W_DROP = 2'd2
    } wstate_t;

    localparam int               DEPTH    = 1 << ADDR_W;
    localparam logic [11:0]      DEPTH_X  = 12'(DEPTH);
    localparam int               ACK_W    = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CYCLES - 1);

    wstate_t           state_q, state_d;
    logic              commit_q;
    logic              pend_q, pend_d;
    logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
    logic [1:0]        count_q, count_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0][10:0]  len_q, len_d;
    logic              ready_q, ready_d;
    logic [7:0]        rd_data_q, rd_data_d;

    logic              accept;
    logic              pop;
    logic              wr_en;
    logic              timeout_fire;
    logic [10:0]       len_clamped;

    logic [7:0] mem [2*DEPTH];

`ifdef JOKER_IN_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
    logic [7:0]  drop_q, drop_d;

    always_comb begin
        timeout_fire = (count_q != 2'd0) && !ep_pkt_done &&
                       (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
        to_cnt_d = to_cnt_q + 32'd1;
        // Any head change (read done or discard) restarts the stale timer.
        if ((count_q == 2'd0) || ep_pkt_done || timeout_fire) begin
            to_cnt_d = 32'd0;
        end
        drop_d = drop_q;
        if (timeout_fire && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= 32'd0;
            drop_q   <= 8'd0;
        end else begin
            to_cnt_q <= to_cnt_d;
            drop_q   <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    // Timeout parameter has no effect in this build; the counter is always zero.
    localparam logic [7:0] DROP_ZERO = (TIMEOUT_CYCLES > 0) ? 8'd0 : 8'd0;

    assign timeout_fire = 1'b0;
    assign drop_cnt     = DROP_ZERO;
`endif

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        ack_cnt_d = ack_cnt_q;
        accept    = 1'b0;

        len_clamped = ({1'b0, usb_in_commit_len} > DEPTH_X) ? DEPTH_X[10:0] : usb_in_commit_len;

        unique case (state_q)
            W_FILL: begin
                if (usb_in_commit) begin
                    // A rising edge seen while both banks were full keeps retrying.
                    if (!commit_q || pend_q) begin
                        if (count_q != 2'd2) begin
                            accept    = 1'b1;
                            pend_d    = 1'b0;
                            ack_cnt_d = '0;
                            state_d   = W_ACK;
                        end else begin
                            pend_d = 1'b1;
                        end
                    end
                end else begin
                    pend_d = 1'b0;
                end
            end
            W_ACK: begin
                if (ack_cnt_q == ACK_LAST) begin
                    state_d = W_DROP;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
                end
            end
            W_DROP: begin
                if (!usb_in_commit) begin
                    state_d = W_FILL;
                end
            end
            default: state_d = W_FILL;
        endcase

        pop = (ep_pkt_done || timeout_fire) && (count_q != 2'd0);

        unique case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        wr_bank_d = wr_bank_q ^ accept;
        rd_bank_d = rd_bank_q ^ pop;

        len_d = len_q;
        if (accept) begin
            len_d[wr_bank_q] = len_clamped;
        end

        ready_d = (count_q != 2'd2) && (state_q == W_FILL);

        wr_en = usb_in_wren && (state_q == W_FILL) && ({1'b0, usb_in_addr} < DEPTH_X);

        rd_data_d = mem[{rd_bank_q, ep_rd_addr[ADDR_W-1:0]}];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= W_FILL;
            commit_q  <= 1'b0;
            pend_q    <= 1'b0;
            ack_cnt_q <= '0;
            count_q   <= 2'd0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            len_q     <= '0;
            ready_q   <= 1'b1;
            rd_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            commit_q  <= usb_in_commit;
            pend_q    <= pend_d;
            ack_cnt_q <= ack_cnt_d;
            count_q   <= count_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            len_q     <= len_d;
            ready_q   <= ready_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_q, usb_in_addr[ADDR_W-1:0]}] <= usb_in_data;
        end
    end

    assign usb_in_commit_ack = (state_q == W_ACK);
    assign usb_in_ready      = ready_q;
    assign ep_rd_data        = rd_data_q;
    assign ep_pkt_avail      = (count_q != 2'd0);
    assign ep_pkt_len        = len_q[rd_bank_q];

endmodule

// File: tb/tb_joker_ep_in_reply.sv
// Randomized bench for joker_ep_in_reply against a packet-queue model (two byte banks + FIFO of lengths).
module tb_joker_ep_in_reply;

    localparam int ADDR_W     = 10;
    localparam int DEPTH      = 1024;
    localparam int ACK_CYCLES = 2;
    localparam int TMO        = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] usb_in_addr;
    logic [7:0]  usb_in_data;
    logic        usb_in_wren;
    logic        usb_in_commit;
    logic [10:0] usb_in_commit_len;
    logic        usb_in_commit_ack;
    logic        usb_in_ready;
    logic [10:0] ep_rd_addr;
    logic [7:0]  ep_rd_data;
    logic        ep_pkt_avail;
    logic [10:0] ep_pkt_len;
    logic        ep_pkt_done;
    logic [7:0]  drop_cnt;

    joker_ep_in_reply #(
        .ADDR_W(ADDR_W),
        .ACK_CYCLES(ACK_CYCLES),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .usb_in_addr(usb_in_addr),
        .usb_in_data(usb_in_data),
        .usb_in_wren(usb_in_wren),
        .usb_in_commit(usb_in_commit),
        .usb_in_commit_len(usb_in_commit_len),
        .usb_in_commit_ack(usb_in_commit_ack),
        .usb_in_ready(usb_in_ready),
        .ep_rd_addr(ep_rd_addr),
        .ep_rd_data(ep_rd_data),
        .ep_pkt_avail(ep_pkt_avail),
        .ep_pkt_len(ep_pkt_len),
        .ep_pkt_done(ep_pkt_done),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: bank contents, ping-pong pointers and a FIFO of queued packets.
    logic [7:0] mbank [2][DEPTH];
    int         mwr = 0;
    int         mrd = 0;
    int         q_len[$];
    int         q_nb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp_len(input int l);
        return (l > DEPTH) ? DEPTH : l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!usb_in_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, usb_in_ready, 1);
    endtask

    task automatic write_byte(input int addr, input logic [7:0] data);
        usb_in_addr = 11'(addr);
        usb_in_data = data;
        usb_in_wren = 1'b1;
        tick();
        usb_in_wren = 1'b0;
        if (addr < DEPTH) mbank[mwr][addr] = data;
    endtask

    task automatic fill_reply(input int nb);
        for (int i = 0; i < nb; i++) write_byte(i, 8'($urandom));
    endtask

    task automatic chk_head(input string tag);
        chk({tag, "_avail"}, ep_pkt_avail, (q_len.size() > 0) ? 1 : 0);
        if (q_len.size() > 0) chk({tag, "_len"}, ep_pkt_len, q_len[0]);
    endtask

    task automatic commit_reply(input int len, input int nb, input bit with_done,
                                input int hold, input string tag);
        int n;
        int ackc;
        usb_in_commit_len = 11'(len);
        usb_in_commit     = 1'b1;
        ep_pkt_done       = with_done;
        tick();
        ep_pkt_done = 1'b0;
        n = 0;
        while (!usb_in_commit_ack && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_ack_seen"}, usb_in_commit_ack, 1);
        if (with_done && q_len.size() > 0) begin
            void'(q_len.pop_front());
            void'(q_nb.pop_front());
            mrd ^= 1;
        end
        q_len.push_back(clamp_len(len));
        q_nb.push_back(nb);
        mwr ^= 1;
        ackc = 0;
        while (usb_in_commit_ack && ackc < 10) begin
            tick();
            ackc++;
        end
        chk({tag, "_ack_width"}, ackc, ACK_CYCLES);
        repeat (hold) tick();
        usb_in_commit = 1'b0;
        tick();
        tick();
        chk_head(tag);
    endtask

    task automatic read_chk(input int addr, input logic [7:0] exp, input string tag);
        ep_rd_addr = 11'(addr);
        tick();
        chk(tag, ep_rd_data, exp);
    endtask

    task automatic pop_head(input string tag);
        int a;
        if (q_nb[0] > 0) begin
            for (int k = 0; k < 3; k++) begin
                a = $urandom_range(0, q_nb[0] - 1);
                read_chk(a, mbank[mrd][a], {tag, "_data"});
            end
        end
        ep_pkt_done = 1'b1;
        tick();
        ep_pkt_done = 1'b0;
        void'(q_len.pop_front());
        void'(q_nb.pop_front());
        mrd ^= 1;
        tick();
        chk_head({tag, "_after"});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int len;
        int n;
        logic [7:0] keep;

        reset             = 1'b1;
        usb_in_addr       = '0;
        usb_in_data       = '0;
        usb_in_wren       = 1'b0;
        usb_in_commit     = 1'b0;
        usb_in_commit_len = '0;
        ep_rd_addr        = '0;
        ep_pkt_done       = 1'b0;
        repeat (3) tick();
        chk("rst_ready", usb_in_ready, 1);
        chk("rst_ack", usb_in_commit_ack, 0);
        chk("rst_avail", ep_pkt_avail, 0);
        chk("rst_len", ep_pkt_len, 0);
        chk("rst_rdata", ep_rd_data, 0);
        chk("rst_drop", drop_cnt, 0);
        reset = 1'b0;
        tick();

        // Basic reply with fixed bytes.
        write_byte(0, 8'h0B);
        write_byte(1, 8'h5A);
        commit_reply(2, 2, 1'b0, 0, "t1");
        read_chk(0, 8'h0B, "t1_rd0");
        read_chk(1, 8'h5A, "t1_rd1");
        pop_head("t1_pop");

        // Fill both banks; a third commit stalls until the head is read.
        wait_ready("t2a");
        fill_reply(5);
        commit_reply(5, 5, 1'b0, 0, "t2a");
        wait_ready("t2b");
        fill_reply(7);
        commit_reply(7, 7, 1'b0, 0, "t2b");
        chk("t2_full_ready", usb_in_ready, 0);
        usb_in_commit_len = 11'd3;
        usb_in_commit     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_blocked_ack", usb_in_commit_ack, 0);
        end
        ep_pkt_done = 1'b1;
        tick();
        ep_pkt_done = 1'b0;
        void'(q_len.pop_front());
        void'(q_nb.pop_front());
        mrd ^= 1;
        n = 0;
        while (!usb_in_commit_ack && n < 20) begin
            tick();
            n++;
        end
        chk("t2_late_ack", usb_in_commit_ack, 1);
        q_len.push_back(3);
        q_nb.push_back(0);
        mwr ^= 1;
        n = 0;
        while (usb_in_commit_ack && n < 10) begin
            tick();
            n++;
        end
        chk("t2_late_ack_width", n, ACK_CYCLES);
        usb_in_commit = 1'b0;
        tick();
        tick();
        chk("t2_still_full", usb_in_ready, 0);
        chk_head("t2_head");
        pop_head("t2_popb");
        pop_head("t2_popc");

        // Zero-length packet, length clamp and out-of-range write.
        wait_ready("t3a");
        commit_reply(0, 0, 1'b0, 0, "t3_zero");
        pop_head("t3_zero_pop");
        wait_ready("t3b");
        fill_reply(600);
        keep = mbank[mwr][476];
        write_byte(1500, ~keep);
        commit_reply(2047, 600, 1'b0, 0, "t3_clamp");
        chk("t3_clamp_len", ep_pkt_len, DEPTH);
        read_chk(476, keep, "t3_oob_write");
        pop_head("t3_pop");

        // Commit accept coinciding with head read.
        wait_ready("t4a");
        fill_reply(4);
        commit_reply(4, 4, 1'b0, 0, "t4a");
        wait_ready("t4b");
        fill_reply(6);
        commit_reply(6, 6, 1'b1, 0, "t4b");
        chk("t4_count_one", q_len.size(), 1);
        chk("t4_ready", usb_in_ready, 1);
        pop_head("t4_pop");

        // Commit held long after ack queues only one packet.
        wait_ready("t5a");
        fill_reply(9);
        commit_reply(9, 9, 1'b0, 10, "t5a");
        wait_ready("t5b");
        fill_reply(3);
        commit_reply(3, 3, 1'b0, 0, "t5b");
        pop_head("t5_pop1");
        pop_head("t5_pop2");

        // Random mix of replies and reads.
        for (int it = 0; it < 40; it++) begin
            if (q_len.size() < 2 && (q_len.size() == 0 || $urandom_range(0, 1) == 1)) begin
                wait_ready("rnd");
                nb  = $urandom_range(0, 24);
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 40);
                fill_reply(nb);
                commit_reply(len, nb, 1'b0, $urandom_range(0, 3), "rnd_commit");
            end else begin
                pop_head("rnd_pop");
            end
        end
        while (q_len.size() > 0) pop_head("drain");

`ifdef JOKER_IN_TIMEOUT_EN
        // Unread packet is discarded after TMO cycles.
        wait_ready("tmo");
        fill_reply(2);
        usb_in_commit_len = 11'd2;
        usb_in_commit     = 1'b1;
        n = 0;
        while (!usb_in_commit_ack && n < 20) begin
            tick();
            n++;
        end
        chk("tmo_ack", usb_in_commit_ack, 1);
        n = 0;
        while (ep_pkt_avail && n < 300) begin
            tick();
            n++;
            if (n == 3) usb_in_commit = 1'b0;
        end
        chk("tmo_cycles", n, TMO);
        chk("tmo_avail", ep_pkt_avail, 0);
        chk("tmo_drop", drop_cnt, 1);
        mwr ^= 1;
        mrd ^= 1;
        tick();
`else
        chk("no_tmo_drop", drop_cnt, 0);
`endif

        // Reset while ack is high.
        wait_ready("rst_mid");
        fill_reply(2);
        usb_in_commit_len = 11'd2;
        usb_in_commit     = 1'b1;
        n = 0;
        while (!usb_in_commit_ack && n < 20) begin
            tick();
            n++;
        end
        chk("rst_mid_ack_pre", usb_in_commit_ack, 1);
        reset         = 1'b1;
        usb_in_commit = 1'b0;
        tick();
        chk("rst_mid_ack", usb_in_commit_ack, 0);
        chk("rst_mid_ready", usb_in_ready, 1);
        chk("rst_mid_avail", ep_pkt_avail, 0);
        chk("rst_mid_drop", drop_cnt, 0);
        reset = 1'b0;
        q_len.delete();
        q_nb.delete();
        mwr = 0;
        mrd = 0;
        tick();
        chk("rst_mid_ready_after", usb_in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
